// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx serializer between NUM_REQ byte producers.
// A per-transfer watchdog raises a sticky error if the transmitter never reports done.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int TIMEOUT_CLKS = 62496,
    parameter int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 i_enable,
    input  logic                 i_clear_error,
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [8*NUM_REQ-1:0] i_req_byte,
    output logic [NUM_REQ-1:0]   o_ack,
    output logic [NUM_REQ-1:0]   o_done,
    output logic [ID_W-1:0]      o_grant_id,
    output logic                 o_busy,
    output logic                 o_error,
    output logic                 o_tx_enable,
    output logic                 o_tx_dv,
    output logic [7:0]           o_tx_byte,
    input  logic                 i_tx_active,
    input  logic                 i_tx_done
);

    localparam int WD_W = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        WAIT_TX = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [ID_W-1:0]      rr_q, rr_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [ID_W-1:0]      grant_q, grant_d;
    logic [7:0]           byte_q, byte_d;
    logic                 tx_en_q, tx_en_d;
    logic                 tx_dv_q, tx_dv_d;
    logic                 error_q, error_d;

    logic [7:0]           req_bytes [NUM_REQ];
    logic                 win_found;
    logic [ID_W-1:0]      win_id;
    int                   scan_idx;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req_bytes
        assign req_bytes[gi] = i_req_byte[8*gi +: 8];
    end

    // Scan requesters starting just after the last one served, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_idx  = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            scan_idx = (int'(rr_q) + off) % NUM_REQ;
            if (!win_found && i_req[ID_W'(scan_idx)]) begin
                win_found = 1'b1;
                win_id    = ID_W'(scan_idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        wd_d    = wd_q;
        ack_d   = '0;
        done_d  = '0;
        grant_d = grant_q;
        byte_d  = byte_q;
        tx_en_d = tx_en_q;
        tx_dv_d = 1'b0;
        error_d = error_q;

        if (i_clear_error) begin
            error_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (i_enable && !error_q && win_found) begin
                    ack_d[win_id] = 1'b1;
                    byte_d        = req_bytes[win_id];
                    grant_d       = win_id;
                    tx_en_d       = 1'b1;
                    state_d       = LAUNCH;
                end
            end
            LAUNCH: begin
                tx_dv_d = 1'b1;
                wd_d    = '0;
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                // A done arriving on the timeout cycle still counts as a clean completion.
                if (i_tx_done) begin
                    done_d[grant_q] = 1'b1;
                    rr_d            = grant_q;
                    tx_en_d         = 1'b0;
                    state_d         = IDLE;
                end else if (wd_q == WD_W'(TIMEOUT_CLKS - 1)) begin
                    error_d = 1'b1;
                    rr_d    = grant_q;
                    tx_en_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rr_q    <= ID_W'(NUM_REQ - 1);
            wd_q    <= '0;
            ack_q   <= '0;
            done_q  <= '0;
            grant_q <= '0;
            byte_q  <= '0;
            tx_en_q <= 1'b0;
            tx_dv_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            wd_q    <= wd_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            grant_q <= grant_d;
            byte_q  <= byte_d;
            tx_en_q <= tx_en_d;
            tx_dv_q <= tx_dv_d;
            error_q <= error_d;
        end
    end

    assign o_ack       = ack_q;
    assign o_done      = done_q;
    assign o_grant_id  = grant_q;
    assign o_busy      = (state_q != IDLE);
    assign o_error     = error_q;
    assign o_tx_enable = tx_en_q;
    assign o_tx_dv     = tx_dv_q;
    assign o_tx_byte   = byte_q;

    // The serializer must be quiet whenever no transfer is owned by the arbiter.
    a_idle_tx_quiet: assert property (@(posedge clock) disable iff (!reset_n)
        (state_q == IDLE) |-> !i_tx_active);

endmodule
